// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Issues word requests over req/ack, buffers one word under stall, drains stale requests on redirect.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        inst_valid
);

   typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] drain_addr_q, drain_addr_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_q, pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = fetch_pc_q + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch: begin
            if (redirect && !imem_ack) begin
               state_d = StDrain;
            end else if (!redirect && imem_ack && stall) begin
               state_d = StHold;
            end
         end
         StHold: begin
            if (redirect || !stall) begin
               state_d = StFetch;
            end
         end
         StDrain: begin
            if (imem_ack) begin
               state_d = StFetch;
            end
         end
         default: state_d = StFetch;
      endcase
   end

   always_comb begin
      imem_req  = (state_q == StFetch || state_q == StDrain) && !rst;
      imem_addr = (state_q == StDrain) ? drain_addr_q : fetch_pc_q;
   end

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      drain_addr_d = drain_addr_q;
      buf_inst_d   = buf_inst_q;
      inst_d       = inst_q;
      pc_d         = pc_q;
      inst_valid_d = inst_valid_q;
      if (redirect) begin
         // Flush wins over stall; a pending request keeps its original address until acked.
         fetch_pc_d   = redirect_pc;
         inst_d       = NOP_INST;
         pc_d         = redirect_pc;
         inst_valid_d = 1'b0;
         if (state_q == StFetch && !imem_ack) begin
            drain_addr_d = fetch_pc_q;
         end
      end else begin
         unique case (state_q)
            StFetch: begin
               if (imem_ack && stall) begin
                  buf_inst_d = imem_rdata;
               end else if (imem_ack) begin
                  inst_d       = imem_rdata;
                  pc_d         = pc_plus4;
                  inst_valid_d = 1'b1;
                  fetch_pc_d   = pc_plus4;
               end else if (!stall) begin
                  inst_d       = NOP_INST;
                  pc_d         = fetch_pc_q;
                  inst_valid_d = 1'b0;
               end
            end
            StHold: begin
               if (!stall) begin
                  inst_d       = buf_inst_q;
                  pc_d         = pc_plus4;
                  inst_valid_d = 1'b1;
                  fetch_pc_d   = pc_plus4;
               end
            end
            StDrain: begin
               if (!stall) begin
                  inst_d       = NOP_INST;
                  pc_d         = fetch_pc_q;
                  inst_valid_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q   <= RESET_PC;
         drain_addr_q <= 32'd0;
         buf_inst_q   <= NOP_INST;
         inst_q       <= NOP_INST;
         pc_q         <= 32'd0;
         inst_valid_q <= 1'b0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         drain_addr_q <= drain_addr_d;
         buf_inst_q   <= buf_inst_d;
         inst_q       <= inst_d;
         pc_q         <= pc_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   assign inst       = inst_q;
   assign pc         = pc_q;
   assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: latency-programmable memory model plus a
// scoreboard of fetched words, alongside directed checks on stall, redirect, wrap and reset.
module tb_fetch_stage;

   localparam logic [31:0] Magic = 32'hA5A5_0000;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_valid;

   int unsigned lat;
   int unsigned cnt;
   logic        drain_flag;
   logic        ev_q;
   logic [63:0] sb_q[$];
   logic [63:0] sb_exp;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] save_inst, save_pc;
   logic        save_valid;

   fetch_stage dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst       (inst),
      .pc         (pc),
      .inst_valid (inst_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory answers lat cycles after the request is first seen (lat=1: same cycle).
   assign imem_ack   = imem_req && (cnt == lat - 1);
   assign imem_rdata = imem_addr ^ Magic;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= 0;
         drain_flag <= 1'b0;
         ev_q       <= 1'b0;
         sb_q.delete();
      end else begin
         cnt <= (imem_req && !imem_ack) ? cnt + 1 : 0;
         if (imem_req && imem_ack) begin
            if (!redirect && !drain_flag) begin
               sb_q.push_back({imem_addr ^ Magic, imem_addr + 32'd4});
            end
            drain_flag <= 1'b0;
         end else if (imem_req && redirect) begin
            drain_flag <= 1'b1;
         end
         ev_q <= !stall && !redirect;
      end
   end

   // An unstalled, unredirected edge that leaves inst_valid high delivers a new instruction.
   always @(negedge clk) begin
      if (!rst && ev_q && inst_valid) begin
         if (sb_q.size() == 0) begin
            check("sb_underrun", 32'(sb_q.size()), 32'd1);
         end else begin
            sb_exp = sb_q.pop_front();
            check("sb_inst", inst, sb_exp[63:32]);
            check("sb_pc", pc, sb_exp[31:0]);
         end
      end
   end

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'd0;
      lat = 1;
      repeat (2) @(negedge clk);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_pc", pc, 32'd0);
      check("rst_valid", 32'(inst_valid), 32'd0);
      rst = 1'b0;
      #1;
      check("first_req", 32'(imem_req), 32'd1);
      check("first_addr", imem_addr, 32'd0);

      for (int i = 0; i < 6; i++) begin
         check("zw_addr", imem_addr, 32'(4 * i));
         check("zw_valid", 32'(inst_valid), (i > 0) ? 32'd1 : 32'd0);
         @(negedge clk);
      end

      lat = 2;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("lat2_valid", 32'(inst_valid), 32'(i % 2));
      end
      check("lat2_addr", imem_addr, 32'd32);

      lat = 1;
      redirect = 1'b1;
      redirect_pc = 32'h0C;
      @(negedge clk);
      redirect = 1'b0;
      check("rd0c_addr", imem_addr, 32'h0C);
      @(negedge clk);
      check("pre_stall_addr", imem_addr, 32'h10);
      stall = 1'b1;
      save_inst = inst;
      save_pc = pc;
      save_valid = inst_valid;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_req", 32'(imem_req), 32'd0);
         check("hold_inst", inst, save_inst);
         check("hold_pc", pc, save_pc);
         check("hold_valid", 32'(inst_valid), 32'(save_valid));
      end
      stall = 1'b0;
      @(negedge clk);
      check("rel_inst", inst, 32'h10 ^ Magic);
      check("rel_pc", pc, 32'h14);
      check("rel_valid", 32'(inst_valid), 32'd1);
      check("rel_addr", imem_addr, 32'h14);

      redirect = 1'b1;
      redirect_pc = 32'h400;
      @(negedge clk);
      redirect = 1'b0;
      check("flush_inst", inst, 32'd0);
      check("flush_pc", pc, 32'h400);
      check("flush_valid", 32'(inst_valid), 32'd0);
      check("flush_addr", imem_addr, 32'h400);
      @(negedge clk);
      check("rd400_valid", 32'(inst_valid), 32'd1);
      check("rd400_pc", pc, 32'h404);

      redirect = 1'b1;
      redirect_pc = 32'h20;
      @(negedge clk);
      redirect = 1'b0;
      check("rd20_addr", imem_addr, 32'h20);
      lat = 3;
      redirect = 1'b1;
      redirect_pc = 32'h200;
      @(negedge clk);
      check("drain_addr0", imem_addr, 32'h20);
      check("drain_flush_pc", pc, 32'h200);
      redirect_pc = 32'h300;
      @(negedge clk);
      redirect = 1'b0;
      check("drain_addr1", imem_addr, 32'h20);
      @(negedge clk);
      check("post_drain_addr", imem_addr, 32'h300);
      check("post_drain_valid", 32'(inst_valid), 32'd0);
      lat = 1;
      @(negedge clk);
      check("rd300_inst", inst, 32'h300 ^ Magic);
      check("rd300_pc", pc, 32'h304);

      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect = 1'b0;
      check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      check("wrap_pc", pc, 32'd0);
      check("wrap_valid", 32'(inst_valid), 32'd1);
      check("wrap_addr1", imem_addr, 32'd0);

      stall = 1'b1;
      @(negedge clk);
      check("mid_hold_req", 32'(imem_req), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_req", 32'(imem_req), 32'd0);
      check("arst_inst", inst, 32'd0);
      check("arst_pc", pc, 32'd0);
      check("arst_valid", 32'(inst_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      stall = 1'b0;
      #1;
      check("rerst_req", 32'(imem_req), 32'd1);
      check("rerst_addr", imem_addr, 32'd0);
      repeat (3) @(negedge clk);
      lat = 1000;
      repeat (2) @(negedge clk);
      #1;
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage. It holds the fetch PC and issues word requests to instruction memory over a req/ack handshake. Fetched instructions and their PC+4 are registered for decode. Hazard stalls hold the stage; taken branches and jumps from later stages redirect the PC and flush the IF/ID register.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset
- NOP_INST, 32'h0000_0000, instruction word driven into IF/ID on bubble or flush

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- stall  in  1  hazard stall: hold PC and IF/ID contents
- redirect  in  1  taken branch/jump this cycle
- redirect_pc  in  32  target PC, valid with redirect
- imem_req  out  1  instruction memory request
- imem_addr  out  32  word address; stable while imem_req high
- imem_ack  in  1  one-cycle pulse: imem_rdata valid; may occur in the same cycle as imem_req rises
- imem_rdata  in  32  instruction word
- inst  out  32  IF/ID instruction, to decode
- pc  out  32  IF/ID PC+4 of inst, to decode
- inst_valid  out  1  IF/ID holds a real instruction

## Operation

- Registers:
  - fetch_pc
  - drain_addr
  - buf_inst
  - state ∈ {FETCH, HOLD, DRAIN}
  - IF/ID: inst, pc, inst_valid
- Outputs:
  - imem_req = (state==FETCH || state==DRAIN) && !rst
  - imem_addr = drain_addr in DRAIN, else fetch_pc
- Priority each cycle: redirect > stall > normal.
- FETCH:
  - ack && !stall && !redirect: IF/ID ← {imem_rdata, fetch_pc+4, 1}; fetch_pc += 4; stay FETCH.
  - ack && stall && !redirect: buf_inst ← imem_rdata; IF/ID unchanged; → HOLD.
  - !ack && !stall && !redirect: IF/ID ← {NOP_INST, fetch_pc, 0} (bubble).
  - !ack && stall: IF/ID unchanged.
  - redirect && ack: rdata discarded; fetch_pc ← redirect_pc; stay FETCH.
  - redirect && !ack: drain_addr ← fetch_pc; fetch_pc ← redirect_pc; → DRAIN. The outstanding request is never cancelled or re-addressed.
- HOLD (imem_req low):
  - !stall && !redirect: IF/ID ← {buf_inst, fetch_pc+4, 1}; fetch_pc += 4; → FETCH.
  - redirect: buf_inst discarded; fetch_pc ← redirect_pc; → FETCH.
- DRAIN (imem_req high, addr = drain_addr):
  - ack: data discarded; → FETCH.
  - redirect in DRAIN (with or without ack): fetch_pc ← redirect_pc; the latest target wins.
- Flush: any redirect sets IF/ID ← {NOP_INST, redirect_pc, 0} at the same edge, regardless of stall.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0, with no flag.
- redirect_pc is used as given; bits [1:0] are not checked.

## Timing

- Reset (async assert, any state):
  - state=FETCH, fetch_pc=RESET_PC, drain_addr=0, buf_inst=NOP_INST
  - inst=NOP_INST, pc=0, inst_valid=0
  - imem_req=0 while rst is high
- First request: imem_req=1, imem_addr=RESET_PC in the first cycle after rst deasserts.
- Throughput:
  - Zero-wait memory (ack in request cycle): one instruction per cycle.
  - inst/pc/inst_valid update at the edge ending the ack cycle, so the instruction reaches decode 1 cycle after ack.
- N-cycle memory: N-1 bubbles (inst_valid=0) per instruction when not stalled.
- Redirect:
  - Redirect at edge E: IF/ID flushed at E.
  - With no request pending, the new address is on imem_addr in the cycle after E.
  - With a request pending, the new address appears in the cycle after the drained ack.
- Stall: inst/pc/inst_valid are bit-stable for every stalled cycle without redirect. At most one instruction is buffered, so imem_req stays low in HOLD.
- Reset mid-DRAIN or mid-HOLD: buffered or pending data is abandoned. The memory must tolerate a dropped request on reset.

## Test plan

- Reset then zero-wait ack every cycle, imem_rdata = addr ^ 32'hA5A5_0000:
  - imem_addr = 0, 4, 8, …
  - inst/pc pairs (0^A5A5_0000, 4), (4^…, 8), …
  - inst_valid=1 from the 2nd cycle.
- 2-cycle memory latency:
  - inst_valid pattern 0,1,0,1.
  - Each pc = request address + 4; no address skipped.
- Stall in an ack cycle at addr 0x10, held 3 cycles:
  - imem_req low 3 cycles; IF/ID holds its prior value.
  - After release, inst = data@0x10, pc=0x14; next imem_addr=0x14.
- redirect_pc=0x400 with a zero-wait ack in the same cycle:
  - Data discarded; IF/ID={NOP,0x400,0}.
  - Next imem_addr=0x400; next inst_valid=1 with pc=0x404.
- redirect_pc=0x200 while a 3-cycle request to 0x20 is pending, plus a second redirect to 0x300 during DRAIN:
  - imem_addr stays 0x20 until ack.
  - Then 0x300; data@0x20 never reaches IF/ID.
- Wrap and reset:
  - redirect to 0xFFFF_FFFC: fetch yields pc=0, next addr=0.
  - Assert rst mid-HOLD: all outputs immediately take their reset values; after release, the first imem_addr=RESET_PC.
